// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scan-position to pixel fetch from a double-buffered image RAM, 3-cycle colour/sync pipeline.
// Rev 1.0 - initial release.
`default_nettype none

module vga_frame_reader #(
  parameter int         H_ACT_START = 114,
  parameter int         V_ACT_START = 34,
  parameter int         IMG_X0      = 16,
  parameter int         IMG_Y0      = 40,
  parameter int         IMG_W       = 160,
  parameter int         IMG_H       = 120,
  parameter int         SCALE_LOG2  = 2,
  parameter int         ADDR_W      = 16,
  parameter int         BUF1_BASE   = 19200,
  parameter logic [8:0] BORDER_RGB  = 9'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        i_h_cnt,
  input  logic [9:0]        i_v_cnt,
  input  logic              i_valid,
  input  logic              i_hys,
  input  logic              i_vys,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [8:0]        i_mem_data,
  output logic [2:0]        o_vga_r,
  output logic [2:0]        o_vga_g,
  output logic [2:0]        o_vga_b,
  output logic              o_hys,
  output logic              o_vys,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic              o_buf_sel
);

  // Window bounds in 11 bits so the right/bottom edges never wrap.
  localparam logic [10:0] c_X_LO = 11'(H_ACT_START + IMG_X0);
  localparam logic [10:0] c_X_HI = 11'(H_ACT_START + IMG_X0 + (IMG_W << SCALE_LOG2));
  localparam logic [10:0] c_Y_LO = 11'(V_ACT_START + IMG_Y0);
  localparam logic [10:0] c_Y_HI = 11'(V_ACT_START + IMG_Y0 + (IMG_H << SCALE_LOG2));
  localparam logic [ADDR_W-1:0] c_IMG_W = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] c_BUF1  = ADDR_W'(BUF1_BASE);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_PEND = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;

  logic [10:0]       w_h, w_v, w_x, w_y, w_col, w_row;
  logic              w_in_img;
  logic              w_frame_start;
  logic [ADDR_W-1:0] w_base, w_addr;

  logic [ADDR_W-1:0] r_addr;
  logic              r_rd;
  logic              r_s1_in_img, r_s1_valid;
  logic              r_s2_in_img, r_s2_valid;
  logic [8:0]        r_rgb;
  logic [2:0]        r_hys_d, r_vys_d;
  logic [1:0]        r_state;
  logic              r_buf_sel, r_ack;

  always_comb begin
    w_h      = {1'b0, i_h_cnt};
    w_v      = {1'b0, i_v_cnt};
    w_x      = w_h - c_X_LO;
    w_y      = w_v - c_Y_LO;
    w_col    = w_x >> SCALE_LOG2;
    w_row    = w_y >> SCALE_LOG2;
    w_in_img = i_valid && (w_h >= c_X_LO) && (w_h < c_X_HI)
                       && (w_v >= c_Y_LO) && (w_v < c_Y_HI);
    w_base   = r_buf_sel ? c_BUF1 : '0;
    w_addr   = w_base + ADDR_W'(w_row) * c_IMG_W + ADDR_W'(w_col);
    w_frame_start = (i_h_cnt == 10'd0) && (i_v_cnt == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_s1_in_img <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s2_in_img <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_rgb       <= 9'h000;
      r_hys_d     <= 3'b000;
      r_vys_d     <= 3'b000;
    end else begin
      if (w_in_img) begin
        r_addr <= w_addr;
      end
      r_rd        <= w_in_img;
      r_s1_in_img <= w_in_img;
      r_s1_valid  <= i_valid;
      r_s2_in_img <= r_s1_in_img;
      r_s2_valid  <= r_s1_valid;
      // RAM data for the stage-2 tags arrives this cycle.
      if (!r_s2_valid) begin
        r_rgb <= 9'h000;
      end else if (r_s2_in_img) begin
        r_rgb <= i_mem_data;
      end else begin
        r_rgb <= BORDER_RGB;
      end
      r_hys_d <= {r_hys_d[1:0], i_hys};
      r_vys_d <= {r_vys_d[1:0], i_vys};
    end
  end

  // Swap handshake: a request is latched in PEND and only honoured at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_ST_IDLE;
      r_buf_sel <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (i_swap_req) begin
            r_state <= c_ST_PEND;
          end
        end
        c_ST_PEND: begin
          if (w_frame_start) begin
            r_buf_sel <= ~r_buf_sel;
            r_ack     <= 1'b1;
            r_state   <= c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (!i_swap_req) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign o_mem_addr = r_addr;
  assign o_mem_rd   = r_rd;
  assign o_vga_r    = r_rgb[8:6];
  assign o_vga_g    = r_rgb[5:3];
  assign o_vga_b    = r_rgb[2:0];
  assign o_hys      = r_hys_d[2];
  assign o_vys      = r_vys_d[2];
  assign o_swap_ack = r_ack;
  assign o_buf_sel  = r_buf_sel;

endmodule

`default_nettype wire
